// File: rtl/inst_fetcher.sv
// Instruction fetch: PC, direct-mapped one-word icache, JAL/BHT next-PC prediction, ROB redirect.
// Latency: 1 cycle from cache hit to registered issue; a miss costs the memory round trip plus one refill-then-hit cycle.
// Backpressure: full_from_iq stalls issue and miss requests; rdy low freezes all state; memory requests hold until served.
module inst_fetcher #(
    parameter int ICACHE_LINES = 256,
    parameter int BHT_SIZE     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        full_from_iq,
    output logic        ok_flag_to_iq,
    output logic [31:0] inst_to_iq,
    output logic [31:0] pc_to_iq,
    output logic [31:0] rollback_pc_to_iq,
    output logic        predicted_jump_to_iq,
    output logic        fetch_flag_to_mc,
    output logic [31:0] fetch_addr_to_mc,
    input  logic        ok_flag_from_mc,
    input  logic [31:0] inst_from_mc,
    input  logic        rollback_flag_from_rob,
    input  logic [31:0] target_pc_from_rob,
    input  logic        bht_update_flag_from_rob,
    input  logic [31:0] bht_update_pc_from_rob,
    input  logic        bht_taken_from_rob
);
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int BHT_W = $clog2(BHT_SIZE);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t state, state_nxt;

    logic [31:0]       pc;
    logic              ok_q;
    logic [31:0]       cache_data [ICACHE_LINES];
    logic [TAG_W-1:0]  cache_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cache_vld;
    logic [1:0]        bht [BHT_SIZE];

    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [BHT_W-1:0]  bht_idx, upd_idx;
    logic [31:0]       line;
    logic              hit;
    logic              issue, miss_req, fill;
    logic [31:0]       j_imm, b_imm, pc_plus4;
    logic [31:0]       pred_next, pred_rb;
    logic              pred_jump;
    logic              unused_bits;

    assign idx      = pc[IDX_W+1:2];
    assign line     = cache_data[idx];
    assign hit      = cache_vld[idx] && (cache_tag[idx] == pc[31:IDX_W+2]);
    assign fill_idx = fetch_addr_to_mc[IDX_W+1:2];
    assign fill_tag = fetch_addr_to_mc[31:IDX_W+2];
    assign bht_idx  = pc[BHT_W+1:2];
    assign upd_idx  = bht_update_pc_from_rob[BHT_W+1:2];
    assign unused_bits = ^{bht_update_pc_from_rob[31:BHT_W+2], bht_update_pc_from_rob[1:0]};

    // A held pulse is masked while frozen and presented again once rdy returns.
    assign ok_flag_to_iq = ok_q & rdy;

    assign pc_plus4 = pc + 32'd4;
    assign j_imm    = {{12{line[31]}}, line[19:12], line[20], line[30:21], 1'b0};
    assign b_imm    = {{20{line[31]}}, line[7], line[30:25], line[11:8], 1'b0};

    always_comb begin
        pred_jump = 1'b0;
        pred_next = pc_plus4;
        pred_rb   = pc_plus4;
        case (line[6:0])
            OP_JAL: begin
                pred_jump = 1'b1;
                pred_next = pc + j_imm;
            end
            OP_BRANCH: begin
                if (bht[bht_idx][1]) begin
                    pred_jump = 1'b1;
                    pred_next = pc + b_imm;
                end else begin
                    pred_rb = pc + b_imm;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (miss_req) state_nxt = WAIT_MEM;
            WAIT_MEM: if (ok_flag_from_mc) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        miss_req = 1'b0;
        fill     = 1'b0;
        case (state)
            IDLE: begin
                if (!rollback_flag_from_rob && !full_from_iq) begin
                    issue    = hit;
                    miss_req = !hit;
                end
            end
            WAIT_MEM: fill = ok_flag_from_mc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                   <= '0;
            ok_q                 <= 1'b0;
            inst_to_iq           <= '0;
            pc_to_iq             <= '0;
            rollback_pc_to_iq    <= '0;
            predicted_jump_to_iq <= 1'b0;
            fetch_flag_to_mc     <= 1'b0;
            fetch_addr_to_mc     <= '0;
            cache_vld            <= '0;
        end else if (rdy) begin
            ok_q <= issue;
            if (issue) begin
                inst_to_iq           <= line;
                pc_to_iq             <= pc;
                rollback_pc_to_iq    <= pred_rb;
                predicted_jump_to_iq <= pred_jump;
            end
            // Redirect wins; an outstanding miss keeps running and still fills its line.
            if (rollback_flag_from_rob)
                pc <= target_pc_from_rob;
            else if (issue)
                pc <= pred_next;
            if (miss_req) begin
                fetch_flag_to_mc <= 1'b1;
                fetch_addr_to_mc <= {pc[31:2], 2'b00};
            end else if (fill) begin
                fetch_flag_to_mc <= 1'b0;
            end
            if (fill)
                cache_vld[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            cache_data[fill_idx] <= inst_from_mc;
            cache_tag[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++)
                bht[i] <= 2'b01;
        end else if (rdy && bht_update_flag_from_rob) begin
            if (bht_taken_from_rob && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!bht_taken_from_rob && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
        end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: program-level reference model feeds an expected-issue queue; a monitor pops on each issue pulse.
module tb_inst_fetcher;
    logic        clk, rst, rdy, full_from_iq;
    logic        ok_flag_to_iq, predicted_jump_to_iq, fetch_flag_to_mc;
    logic [31:0] inst_to_iq, pc_to_iq, rollback_pc_to_iq, fetch_addr_to_mc;
    logic        ok_flag_from_mc, rollback_flag_from_rob, bht_update_flag_from_rob, bht_taken_from_rob;
    logic [31:0] inst_from_mc, target_pc_from_rob, bht_update_pc_from_rob;

    inst_fetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .full_from_iq(full_from_iq),
        .ok_flag_to_iq(ok_flag_to_iq), .inst_to_iq(inst_to_iq), .pc_to_iq(pc_to_iq),
        .rollback_pc_to_iq(rollback_pc_to_iq), .predicted_jump_to_iq(predicted_jump_to_iq),
        .fetch_flag_to_mc(fetch_flag_to_mc), .fetch_addr_to_mc(fetch_addr_to_mc),
        .ok_flag_from_mc(ok_flag_from_mc), .inst_from_mc(inst_from_mc),
        .rollback_flag_from_rob(rollback_flag_from_rob), .target_pc_from_rob(target_pc_from_rob),
        .bht_update_flag_from_rob(bht_update_flag_from_rob),
        .bht_update_pc_from_rob(bht_update_pc_from_rob), .bht_taken_from_rob(bht_taken_from_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rb;
        logic        pj;
    } exp_t;

    localparam int K_OTHER = 0, K_JAL = 1, K_BR = 2;

    int          checks = 0, failures = 0;
    exp_t        exp_q[$];
    logic [31:0] mem_inst [1024];
    logic [31:0] mem_off  [1024];
    int          mem_kind [1024];
    int          ctr [256];
    logic [31:0] pc_model;
    bit          mc_manual;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_jal(input logic [31:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [31:0] off, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    // Program-level view: what the next issued instruction is, and where fetch goes after it.
    function automatic exp_t model_issue();
        exp_t e;
        logic [9:0] w;
        logic [7:0] b;
        w = pc_model[11:2];
        b = pc_model[9:2];
        e.pc = pc_model;
        e.inst = mem_inst[w];
        e.pj = 1'b0;
        e.rb = pc_model + 32'd4;
        if (mem_kind[w] == K_JAL || (mem_kind[w] == K_BR && ctr[b] >= 2)) begin
            e.pj = 1'b1;
            pc_model = pc_model + mem_off[w];
        end else begin
            if (mem_kind[w] == K_BR)
                e.rb = pc_model + mem_off[w];
            pc_model = pc_model + 32'd4;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && ok_flag_to_iq === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue pc_to_iq=%h expected=no issue", pc_to_iq);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_pc", pc_to_iq, e.pc);
                chk("issue_inst", inst_to_iq, e.inst);
                chk("issue_rollback_pc", rollback_pc_to_iq, e.rb);
                chk("issue_pred_jump", {31'd0, predicted_jump_to_iq}, {31'd0, e.pj});
            end
        end
    end

    // Memory controller: answers each held request after a random latency.
    initial begin
        forever begin
            step();
            if (!mc_manual && !rst && fetch_flag_to_mc) begin
                repeat ($urandom_range(0, 3)) step();
                ok_flag_from_mc = 1'b1;
                inst_from_mc = mem_inst[fetch_addr_to_mc[11:2]];
                step();
                ok_flag_from_mc = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic run_k(input int k, input bit jitter, output int first, output int last);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < k; i++) exp_q.push_back(model_issue());
        full_from_iq = 1'b0;
        while (n < k) begin
            step();
            cyc++;
            if (ok_flag_to_iq) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (n >= k) begin
                full_from_iq = 1'b1;
                rdy = 1'b1;
            end else if (cyc > 300) begin
                checks++;
                failures++;
                $display("FAIL run_timeout issued=%0d required=%0d", n, k);
                finish_now();
            end else begin
                rdy = jitter ? ($urandom_range(0, 5) != 0) : 1'b1;
            end
        end
    endtask

    task automatic do_rollback(input logic [31:0] t);
        rollback_flag_from_rob = 1'b1;
        target_pc_from_rob = t;
        step();
        rollback_flag_from_rob = 1'b0;
        pc_model = t;
    endtask

    task automatic do_bht(input logic [31:0] p, input bit taken);
        bht_update_flag_from_rob = 1'b1;
        bht_update_pc_from_rob = p;
        bht_taken_from_rob = taken;
        step();
        bht_update_flag_from_rob = 1'b0;
        if (taken && ctr[p[9:2]] < 3) ctr[p[9:2]]++;
        if (!taken && ctr[p[9:2]] > 0) ctr[p[9:2]]--;
    endtask

    initial begin
        int f, l;
        rst = 1'b1; rdy = 1'b1; full_from_iq = 1'b1; mc_manual = 1'b1;
        ok_flag_from_mc = 1'b0; inst_from_mc = '0;
        rollback_flag_from_rob = 1'b0; target_pc_from_rob = '0;
        bht_update_flag_from_rob = 1'b0; bht_update_pc_from_rob = '0; bht_taken_from_rob = 1'b0;
        pc_model = '0;
        for (int i = 0; i < 256; i++) ctr[i] = 1;
        for (int w = 0; w < 1024; w++) begin
            int r;
            logic [31:0] rnd;
            rnd = $urandom;
            mem_kind[w] = K_OTHER;
            mem_off[w] = ($urandom_range(0, 64) - 32) * 4;
            if (w < 128) begin
                mem_inst[w] = 32'h00000013;
            end else begin
                r = $urandom_range(0, 7);
                if (r <= 2) mem_inst[w] = {rnd[31:7], 7'b0010011};
                else if (r == 3) mem_inst[w] = {rnd[31:7], 7'b1100111};
                else if (r == 7) mem_inst[w] = {rnd[31:7], 7'b0110111};
                else if (r == 6) begin
                    mem_kind[w] = K_JAL;
                    mem_inst[w] = enc_jal(mem_off[w], rnd[11:7]);
                end else begin
                    mem_kind[w] = K_BR;
                    mem_inst[w] = enc_br(mem_off[w], rnd[19:15], rnd[24:20], rnd[14:12]);
                end
            end
        end
        mem_kind[8] = K_JAL;  mem_off[8] = 32'd16; mem_inst[8] = enc_jal(32'd16, 5'd0);
        mem_kind[16] = K_BR;  mem_off[16] = 32'd8; mem_inst[16] = enc_br(32'd8, 5'd0, 5'd0, 3'd0);

        repeat (2) step();
        chk("reset_ok", {31'd0, ok_flag_to_iq}, 32'd0);
        chk("reset_inst", inst_to_iq, 32'd0);
        chk("reset_pc_to_iq", pc_to_iq, 32'd0);
        chk("reset_rollback_pc", rollback_pc_to_iq, 32'd0);
        chk("reset_pred_jump", {31'd0, predicted_jump_to_iq}, 32'd0);
        chk("reset_fetch_flag", {31'd0, fetch_flag_to_mc}, 32'd0);
        chk("reset_fetch_addr", fetch_addr_to_mc, 32'd0);
        rst = 1'b0;
        step();

        // First miss served by hand: request held, no bypass, then issue.
        exp_q.push_back(model_issue());
        full_from_iq = 1'b0;
        step();
        chk("first_req_flag", {31'd0, fetch_flag_to_mc}, 32'd1);
        chk("first_req_addr", fetch_addr_to_mc, 32'd0);
        repeat (2) begin
            step();
            chk("req_held", {31'd0, fetch_flag_to_mc}, 32'd1);
        end
        ok_flag_from_mc = 1'b1;
        inst_from_mc = 32'h00000013;
        step();
        ok_flag_from_mc = 1'b0;
        chk("no_bypass", {31'd0, ok_flag_to_iq}, 32'd0);
        chk("req_dropped", {31'd0, fetch_flag_to_mc}, 32'd0);
        step();
        chk("first_issue", {31'd0, ok_flag_to_iq}, 32'd1);
        full_from_iq = 1'b1;
        step();
        full_from_iq = 1'b0;
        step();
        chk("second_req_addr", fetch_addr_to_mc, 32'd4);
        mc_manual = 1'b0;
        run_k(3, 1'b0, f, l);

        // Warm lines 0..12 issue back to back, then a stall holds pc at 0x10.
        do_rollback(32'h0);
        run_k(4, 1'b0, f, l);
        chk("warm_first_latency", f, 1);
        chk("warm_back_to_back", l - f, 3);
        repeat (2) begin
            step();
            chk("stall_no_issue", {31'd0, ok_flag_to_iq}, 32'd0);
        end
        full_from_iq = 1'b0;
        step();
        chk("stall_held_pc", fetch_addr_to_mc, 32'h10);
        run_k(1, 1'b0, f, l);

        do_rollback(32'h20);
        run_k(2, 1'b0, f, l);
        do_rollback(32'h40);
        run_k(2, 1'b0, f, l);
        do_bht(32'h40, 1'b1);
        do_bht(32'h40, 1'b1);
        do_rollback(32'h40);
        run_k(2, 1'b0, f, l);
        chk("bht_refetch_hit", f, 1);

        // Rollback while waiting: the request completes and fills, fetch restarts at target.
        mc_manual = 1'b1;
        do_rollback(32'h188);
        full_from_iq = 1'b0;
        step();
        chk("wait_req_addr", fetch_addr_to_mc, 32'h188);
        full_from_iq = 1'b1;
        do_rollback(32'h100);
        step();
        chk("wait_req_kept", {31'd0, fetch_flag_to_mc}, 32'd1);
        chk("wait_req_addr_kept", fetch_addr_to_mc, 32'h188);
        ok_flag_from_mc = 1'b1;
        inst_from_mc = mem_inst[32'h188 >> 2];
        step();
        ok_flag_from_mc = 1'b0;
        chk("wait_fill_done", {31'd0, fetch_flag_to_mc}, 32'd0);
        full_from_iq = 1'b0;
        step();
        chk("redirect_req_addr", fetch_addr_to_mc, 32'h100);
        mc_manual = 1'b0;
        run_k(1, 1'b0, f, l);
        do_rollback(32'h188);
        run_k(1, 1'b0, f, l);
        chk("filled_line_hits", f, 1);

        // Rollback in the same cycle as the memory response.
        mc_manual = 1'b1;
        do_rollback(32'h18C);
        full_from_iq = 1'b0;
        step();
        chk("coincide_req_addr", fetch_addr_to_mc, 32'h18C);
        full_from_iq = 1'b1;
        rollback_flag_from_rob = 1'b1;
        target_pc_from_rob = 32'h140;
        ok_flag_from_mc = 1'b1;
        inst_from_mc = mem_inst[32'h18C >> 2];
        step();
        rollback_flag_from_rob = 1'b0;
        ok_flag_from_mc = 1'b0;
        pc_model = 32'h140;
        chk("coincide_fill", {31'd0, fetch_flag_to_mc}, 32'd0);
        full_from_iq = 1'b0;
        step();
        chk("coincide_redirect", fetch_addr_to_mc, 32'h140);
        mc_manual = 1'b0;
        run_k(1, 1'b0, f, l);
        do_rollback(32'h18C);
        run_k(1, 1'b0, f, l);
        chk("coincide_filled_hits", f, 1);

        do_rollback(32'h800);
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r <= 2) run_k($urandom_range(1, 8), 1'b1, f, l);
            else if (r == 3) do_bht(32'h800 + $urandom_range(0, 511) * 4, $urandom_range(0, 1) == 1);
            else if (r == 4) do_rollback(32'h800 + $urandom_range(0, 511) * 4);
            else run_k($urandom_range(1, 8), 1'b0, f, l);
        end

        // Reset during a miss: request drops at once, a late response is ignored.
        mc_manual = 1'b1;
        do_rollback(32'h1C0);
        full_from_iq = 1'b0;
        step();
        chk("pre_reset_req", {31'd0, fetch_flag_to_mc}, 32'd1);
        full_from_iq = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset_drops_req", {31'd0, fetch_flag_to_mc}, 32'd0);
        step();
        rst = 1'b0;
        pc_model = '0;
        for (int i = 0; i < 256; i++) ctr[i] = 1;
        step();
        ok_flag_from_mc = 1'b1;
        inst_from_mc = 32'hDEADBEEF;
        step();
        ok_flag_from_mc = 1'b0;
        chk("late_ok_no_issue", {31'd0, ok_flag_to_iq}, 32'd0);
        chk("late_ok_flag_low", {31'd0, fetch_flag_to_mc}, 32'd0);
        full_from_iq = 1'b0;
        step();
        chk("late_ok_no_fill", {31'd0, fetch_flag_to_mc}, 32'd1);
        mc_manual = 1'b0;
        run_k(1, 1'b0, f, l);
        do_rollback(32'h40);
        run_k(1, 1'b0, f, l);

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 32'd0);
        finish_now();
    end
endmodule
